// File: rtl/game_pkg.sv
// Shared game constants: FSM state encoding and the vga_sync line used as the frame marker.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAYING  = 2'd1,
        DYING    = 2'd2,
        GAMEOVER = 2'd3
    } game_state_t;

    // First vertical blanking line of the 640x480 timing.
    localparam int TICK_LINE_DEF = 480;

    localparam int CNT_W = 8;

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame pulse on the first clock where y reaches TICK_LINE.
module frame_tick_gen
    import game_pkg::*;
#(
    parameter int TICK_LINE = TICK_LINE_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] y,
    output logic       frame_tick
);

    localparam logic [9:0] TICK_Y = 10'(TICK_LINE);

    logic [9:0] y_p0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_p0       <= '0;
            frame_tick <= 1'b0;
        end else begin
            y_p0       <= y;
            frame_tick <= (y == TICK_Y) && (y_p0 != TICK_Y);
        end
    end

endmodule

// File: rtl/game_state_controller.sv
// Game sequencing FSM: idle, playing, frozen after a hit, and blinking game-over with a
// minimum hold before a restart is accepted.
module game_state_controller
    import game_pkg::*;
#(
    parameter int DYING_FRAMES = 60,
    parameter int BLINK_FRAMES = 30,
    parameter int HOLD_FRAMES  = 120,
    parameter int TICK_LINE    = TICK_LINE_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       start_btn,
    input  logic       collision,
    output logic       game_en,
    output logic       game_reset,
    output logic       gameover_en,
    output logic [1:0] state,
    output logic       frame_tick
);

    if (DYING_FRAMES < 1 || DYING_FRAMES > 255 ||
        BLINK_FRAMES < 1 || BLINK_FRAMES > 255 ||
        HOLD_FRAMES  < 1 || HOLD_FRAMES  > 255) begin : g_param_check
        $error("game_state_controller: frame parameters must lie in 1..255");
    end

    localparam logic [CNT_W-1:0] DYING_LAST = CNT_W'(DYING_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(HOLD_FRAMES);

    logic unused_x;
    assign unused_x = ^x;

    logic start_p0, start_p1, start_p2, start_edge;

    game_state_t            state_q, state_d;
    logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]       blink_cnt_q, blink_cnt_d;
    logic                   blink_phase_q, blink_phase_d;
    logic                   game_reset_d;
    logic                   hold_done;

    frame_tick_gen #(.TICK_LINE(TICK_LINE)) u_frame_tick_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .y          (y),
        .frame_tick (frame_tick)
    );

    // Start button: two synchroniser flops, then registered rising-edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_p0   <= 1'b0;
            start_p1   <= 1'b0;
            start_p2   <= 1'b0;
            start_edge <= 1'b0;
        end else begin
            start_p0   <= start_btn;
            start_p1   <= start_p0;
            start_p2   <= start_p1;
            start_edge <= start_p1 & ~start_p2;
        end
    end

    // Registered count, so a start landing on the hold-completing tick is still refused.
    assign hold_done = (frame_cnt_q == HOLD_MAX);

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        game_reset_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d      = PLAYING;
                    game_reset_d = 1'b1;
                end
            end
            PLAYING: begin
                if (collision) begin
                    state_d     = DYING;
                    frame_cnt_d = '0;
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (frame_cnt_q == DYING_LAST) begin
                        state_d       = GAMEOVER;
                        frame_cnt_d   = '0;
                        blink_cnt_d   = '0;
                        blink_phase_d = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            GAMEOVER: begin
                if (frame_tick) begin
                    if (!hold_done) frame_cnt_d = frame_cnt_q + 1'b1;
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d   = '0;
                        blink_phase_d = ~blink_phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                if (start_edge && hold_done) begin
                    state_d      = PLAYING;
                    game_reset_d = 1'b1;
                end
            end
        endcase
    end

    // Outputs are registered from next-state so they align with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            frame_cnt_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            game_en       <= 1'b0;
            game_reset    <= 1'b0;
            gameover_en   <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            game_en       <= (state_d == PLAYING);
            game_reset    <= game_reset_d;
            gameover_en   <= (state_d == GAMEOVER) && blink_phase_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller: directed scenarios plus random play against a tick-count model.
module tb_game_state_controller;

    localparam int DYING_FRAMES = 60;
    localparam int BLINK_FRAMES = 30;
    localparam int HOLD_FRAMES  = 120;
    localparam int TICK_LINE    = 480;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       start_btn = 1'b0;
    logic       collision = 1'b0;
    logic       game_en, game_reset, gameover_en, frame_tick;
    logic [1:0] state;

    game_state_controller #(
        .DYING_FRAMES (DYING_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .HOLD_FRAMES  (HOLD_FRAMES),
        .TICK_LINE    (TICK_LINE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (x),
        .y           (y),
        .start_btn   (start_btn),
        .collision   (collision),
        .game_en     (game_en),
        .game_reset  (game_reset),
        .gameover_en (gameover_en),
        .state       (state),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: state code, frames elapsed in the current state, input histories.
    int m_state;
    int m_ticks;
    bit m_reset_pulse;
    bit m_tick_out;
    bit bh [0:4];
    int yh [0:2];

    bit btn_lvl = 1'b0;
    bit coll_lvl = 1'b0;
    int frame_pos = 0;
    int flen = 2;
    int tick_seen = 0;
    int pulse_seen = 0;
    int first_pulse = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ticks = 0;
        m_reset_pulse = 1'b0;
        m_tick_out = 1'b0;
        for (int i = 0; i < 5; i++) bh[i] = 1'b0;
        for (int i = 0; i < 3; i++) yh[i] = 0;
    endtask

    task automatic model_edge();
        bit se, tk;
        for (int i = 4; i > 0; i--) bh[i] = bh[i-1];
        bh[0] = start_btn;
        for (int i = 2; i > 0; i--) yh[i] = yh[i-1];
        yh[0] = int'(y);
        // Button seen 3 edges ago, and not 4 edges ago, reaches the FSM now.
        se = bh[3] && !bh[4];
        tk = (yh[1] == TICK_LINE) && (yh[2] != TICK_LINE);
        m_reset_pulse = 1'b0;
        case (m_state)
            0: if (se) begin m_state = 1; m_reset_pulse = 1'b1; end
            1: if (collision) begin m_state = 2; m_ticks = 0; end
            2: if (tk) begin
                   m_ticks++;
                   if (m_ticks == DYING_FRAMES) begin m_state = 3; m_ticks = 0; end
               end
            default: begin
                if (se && m_ticks >= HOLD_FRAMES) begin
                    m_state = 1;
                    m_reset_pulse = 1'b1;
                end else if (tk) begin
                    m_ticks++;
                end
            end
        endcase
        m_tick_out = (yh[0] == TICK_LINE) && (yh[1] != TICK_LINE);
    endtask

    task automatic check_outputs();
        bit exp_goe;
        exp_goe = (m_state == 3) && (((m_ticks / BLINK_FRAMES) % 2) == 0);
        check("state", 32'(state), 32'(m_state));
        check("game_en", 32'(game_en), 32'(m_state == 1));
        check("game_reset", 32'(game_reset), 32'(m_reset_pulse));
        check("gameover_en", 32'(gameover_en), 32'(exp_goe));
        check("frame_tick", 32'(frame_tick), 32'(m_tick_out));
    endtask

    function automatic logic [9:0] ry();
        int v;
        v = $urandom_range(0, 1022);
        if (v >= TICK_LINE) v++;
        return 10'(v);
    endfunction

    task automatic step(input bit b, input logic [9:0] yy, input bit c);
        start_btn = b;
        y = yy;
        collision = c;
        x = 10'($urandom_range(0, 639));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (frame_tick === 1'b1) tick_seen++;
        if (game_reset === 1'b1) pulse_seen++;
    endtask

    task automatic step_auto();
        logic [9:0] yv;
        if (frame_pos >= flen) begin
            yv = 10'(TICK_LINE);
            frame_pos = 0;
            flen = $urandom_range(1, 4);
        end else begin
            yv = ry();
            frame_pos++;
        end
        step(btn_lvl, yv, coll_lvl);
    endtask

    task automatic run_until(input int n);
        int guard;
        guard = 0;
        while (m_ticks < n && guard < 5000) begin
            step_auto();
            guard++;
        end
        check("run_until_bound", 32'(guard < 5000), 32'd1);
    endtask

    task automatic do_async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_game_en", 32'(game_en), 32'd0);
        check("arst_game_reset", 32'(game_reset), 32'd0);
        check("arst_gameover_en", 32'(gameover_en), 32'd0);
        check("arst_frame_tick", 32'(frame_tick), 32'd0);
        model_reset();
        frame_pos = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        check("reset_state", 32'(state), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Three full vertical sweeps in IDLE
        tick_seen = 0;
        for (int f = 0; f < 3; f++)
            for (int v = 0; v < 525; v++) step(1'b0, 10'(v), 1'b0);
        check("sweep_ticks", 32'(tick_seen), 32'd3);
        check("sweep_idle", 32'(state), 32'd0);

        // Start held 10 clocks
        pulse_seen = 0;
        first_pulse = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, ry(), 1'b0);
            if (game_reset === 1'b1 && first_pulse < 0) first_pulse = i;
        end
        btn_lvl = 1'b0;
        step(1'b0, ry(), 1'b0);
        check("start_pulses", 32'(pulse_seen), 32'd1);
        check("start_latency", 32'(first_pulse), 32'd3);
        check("playing_state", 32'(state), 32'd1);
        check("playing_en", 32'(game_en), 32'd1);

        // Collision for one clock, then the dying freeze
        step(1'b0, ry(), 1'b1);
        check("hit_game_en", 32'(game_en), 32'd0);
        check("hit_state", 32'(state), 32'd2);
        coll_lvl = 1'b0;
        run_until(DYING_FRAMES - 1);
        while (m_state == 2 && frame_pos < 100) step_auto();
        check("gameover_state", 32'(state), 32'd3);
        check("gameover_first_en", 32'(gameover_en), 32'd1);

        // Blink phases, with an early start press that must be ignored
        run_until(15);
        check("blink_a", 32'(gameover_en), 32'd1);
        run_until(45);
        check("blink_b", 32'(gameover_en), 32'd0);
        run_until(50);
        btn_lvl = 1'b1;
        repeat (5) step_auto();
        btn_lvl = 1'b0;
        repeat (2) step_auto();
        check("early_start_ignored", 32'(state), 32'd3);
        run_until(75);
        check("blink_c", 32'(gameover_en), 32'd1);

        // Start landing on the same edge as the hold-completing tick
        run_until(HOLD_FRAMES - 1);
        step(1'b1, ry(), 1'b0);
        step(1'b1, ry(), 1'b0);
        step(1'b1, 10'(TICK_LINE), 1'b0);
        step(1'b1, ry(), 1'b0);
        check("coincident_start_state", 32'(state), 32'd3);
        check("coincident_start_reset", 32'(game_reset), 32'd0);
        repeat (3) step(1'b0, ry(), 1'b0);

        // Hold complete: a start press restarts the game
        pulse_seen = 0;
        for (int i = 0; i < 6; i++) step(1'b1, ry(), 1'b0);
        repeat (2) step(1'b0, ry(), 1'b0);
        check("restart_pulses", 32'(pulse_seen), 32'd1);
        check("restart_state", 32'(state), 32'd1);
        check("restart_gameover_en", 32'(gameover_en), 32'd0);

        // Collision and start edge on the same edge: collision wins
        pulse_seen = 0;
        step(1'b1, ry(), 1'b0);
        step(1'b1, ry(), 1'b0);
        step(1'b1, ry(), 1'b0);
        step(1'b1, ry(), 1'b1);
        check("coll_start_state", 32'(state), 32'd2);
        check("coll_start_no_reset", 32'(pulse_seen), 32'd0);
        step(1'b0, ry(), 1'b0);
        repeat (6) step_auto();

        // Asynchronous reset while dying
        check("pre_arst_dying", 32'(state), 32'd2);
        do_async_reset();
        repeat (4) step_auto();

        // Random play
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 7) == 0) btn_lvl = !btn_lvl;
            coll_lvl = ($urandom_range(0, 29) == 0);
            step_auto();
            if ($urandom_range(0, 3999) == 0) do_async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
